mem_copy_engine: RTL and testbench

- Initiator-side block for the dual-read/single-write `mem` block. It drives `mem`'s two read ports and its write port to copy a block of bytes from a source address range to a destination address range.
- Bulk moves are offloaded from the processor. The processor issues one start request and waits for `done`.
- Each iteration reads a source byte pair through both read ports in one cycle, then writes the pair back through the single write port in two cycles.

---
 rtl/mem_copy_engine_pkg.sv | 20 ++
 rtl/mem_copy_engine.sv | 143 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   state_e      : FSM state encoding (3 bits)
//   DefaultWidth : default data/address width
//   MemDepth     : number of bytes in the attached dual-read/single-write memory
package mem_copy_engine_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StCap  = 3'd2,
    StWr0  = 3'd3,
    StWr1  = 3'd4,
    StAdv  = 3'd5,
    StDone = 3'd6
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MemDepth     = 256;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy engine driving a dual-read/single-write byte memory.
// Each iteration reads a byte pair through both read ports in one cycle, then writes the
// pair back one byte per cycle through the single write port. Copies ascend pairwise.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start, src, dst, len   : copy request; operands captured when start is accepted in idle
//   busy                   : high from the cycle after an accepted start until done is left
//   done                   : one-cycle completion pulse
//   mem_rd_addr1/2         : even/odd read addresses (src+i, src+i+1)
//   mem_rd_data1/2         : read data, valid one cycle after the address
//   mem_wr_addr/data/en    : write port, each byte held for exactly one cycle
// All outputs are registered.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned n = DefaultWidth
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] src,
  input  logic [n-1:0] dst,
  input  logic [n-1:0] len,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] mem_rd_addr1,
  input  logic [n-1:0] mem_rd_data1,
  output logic [n-1:0] mem_rd_addr2,
  input  logic [n-1:0] mem_rd_data2,
  output logic [n-1:0] mem_wr_addr,
  output logic [n-1:0] mem_wr_data,
  output logic         mem_wr_en
);

  localparam logic [n-1:0] AddrOne = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n:0]   IdxOne  = {{n{1'b0}}, 1'b1};
  localparam logic [n:0]   IdxTwo  = {{(n-1){1'b0}}, 2'b10};

  state_e       state_q;
  logic [n-1:0] src_q;
  logic [n-1:0] dst_q;
  logic [n-1:0] len_q;
  logic [n:0]   i_q;     // one extra bit so i can reach len without aliasing
  logic [n-1:0] b1_q;    // odd byte; the even byte is held directly in mem_wr_data

  logic [n:0]   rem;
  logic [n:0]   step;
  logic [n:0]   i_next;
  logic [n-1:0] rd_base_next;

  always_comb begin
    rem          = {1'b0, len_q} - i_q;
    step         = (rem >= IdxTwo) ? IdxTwo : rem;
    i_next       = i_q + step;
    rd_base_next = src_q + i_next[n-1:0];
  end

  // Outputs are registered, so each transition loads the values the target state drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      i_q          <= '0;
      b1_q         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_rd_addr1 <= '0;
      mem_rd_addr2 <= '0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            i_q   <= '0;
            busy  <= 1'b1;
            if (len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q      <= StRd;
              mem_rd_addr1 <= src;
              mem_rd_addr2 <= src + AddrOne;
            end
          end
        end
        StRd: begin
          // Read data becomes valid at this edge; it stays valid through the capture edge.
          state_q <= StCap;
        end
        StCap: begin
          b1_q        <= mem_rd_data2;
          mem_wr_data <= mem_rd_data1;
          mem_wr_addr <= dst_q + i_q[n-1:0];
          mem_wr_en   <= 1'b1;
          state_q     <= StWr0;
        end
        StWr0: begin
          if (rem == IdxOne) begin
            // Final odd byte: the captured odd byte is dropped.
            mem_wr_en <= 1'b0;
            state_q   <= StAdv;
          end else begin
            mem_wr_addr <= dst_q + i_q[n-1:0] + AddrOne;
            mem_wr_data <= b1_q;
            state_q     <= StWr1;
          end
        end
        StWr1: begin
          mem_wr_en <= 1'b0;
          state_q   <= StAdv;
        end
        StAdv: begin
          i_q <= i_next;
          if (i_next == {1'b0, len_q}) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            state_q      <= StRd;
            mem_rd_addr1 <= rd_base_next;
            mem_rd_addr2 <= rd_base_next + AddrOne;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural byte memory on the DUT side and an
// ascending pairwise copy model on the checking side.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] src, dst, len;
  logic       busy, done;
  logic [7:0] mem_rd_addr1, mem_rd_data1, mem_rd_addr2, mem_rd_data2;
  logic [7:0] mem_wr_addr, mem_wr_data;
  logic       mem_wr_en;

  logic [7:0] mem     [MemDepth];
  logic [7:0] exp_mem [MemDepth];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  int         wr_total;
  int         n_checks;
  int         n_fail;

  mem_copy_engine #(.n(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .mem_rd_addr1 (mem_rd_addr1),
    .mem_rd_data1 (mem_rd_data1),
    .mem_rd_addr2 (mem_rd_addr2),
    .mem_rd_data2 (mem_rd_data2),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_en    (mem_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: addresses and writes are sampled at the falling edge.
  always @(negedge clk) begin
    mem_rd_data1 <= mem[mem_rd_addr1];
    mem_rd_data2 <= mem[mem_rd_addr2];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  always @(negedge clk) if (mem_wr_en) wr_total <= wr_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(posedge clk);
    #1;
    pl_en   = 1'b1;
    pl_addr = 8'(a);
    pl_data = d;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
    exp_mem[a & 255] = d;
  endtask

  // Reference: ascending pairs, each pair read after all earlier pairs are written.
  task automatic model_copy(input int s, input int d, input int l);
    logic [7:0] a, b;
    for (int p = 0; p < l; p += 2) begin
      a = exp_mem[(s + p) & 255];
      b = exp_mem[(s + p + 1) & 255];
      exp_mem[(d + p) & 255] = a;
      if (p + 1 < l) exp_mem[(d + p + 1) & 255] = b;
    end
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < MemDepth; k++) if (mem[k] !== exp_mem[k]) bad++;
    check(tag, bad, 0);
  endtask

  // Issues a copy; optional second start pulse at cycle inj. Returns cycles to done pulse
  // (counted in falling edges after the start edge) and the number of write cycles.
  task automatic run_copy(input int s, input int d, input int l, input int inj,
                          output int cycles, output int writes);
    int w0;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    src = 8'(s);
    dst = 8'(d);
    len = 8'(l);
    w0 = wr_total;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
      if (inj != 0 && cycles == inj) begin
        check("busy_mid", busy, 1);
        start = 1'b1;
        src = 8'd50;
        dst = 8'd200;
        len = 8'd2;
      end else if (inj != 0 && cycles == inj + 1) begin
        start = 1'b0;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after", busy, 0);
    writes = wr_total - w0;
    model_copy(s, d, l);
  endtask

  initial begin
    int cyc, wrs;
    int s, d, l;
    logic [7:0] old_mem [4];
    n_checks = 0;
    n_fail   = 0;
    wr_total = 0;
    reset = 1'b1;
    start = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rd_addr1", mem_rd_addr1, 0);
    check("rst_rd_addr2", mem_rd_addr2, 0);
    check("rst_wr_addr", mem_wr_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    reset = 1'b0;

    for (int k = 0; k < MemDepth; k++) poke(k, 8'($urandom));
    for (int k = 0; k < 4; k++) poke(16 + k, 8'(k + 1));

    // Basic even-length copy
    run_copy(16, 128, 4, 0, cyc, wrs);
    check("basic_cycles", cyc, 11);
    check("basic_writes", wrs, 4);
    for (int k = 0; k < 4; k++) check("basic_byte", mem[128 + k], k + 1);
    check("basic_132", mem[132], exp_mem[132]);
    check_image("basic_image");

    // Odd length
    run_copy(16, 64, 3, 0, cyc, wrs);
    check("odd_cycles", cyc, 10);
    check("odd_writes", wrs, 3);
    check("odd_67", mem[67], exp_mem[67]);
    check_image("odd_image");

    // Zero length
    run_copy(5, 9, 0, 0, cyc, wrs);
    check("zero_cycles", cyc, 1);
    check("zero_writes", wrs, 0);

    // Wrap-around of both read addresses and the pair order
    for (int k = 0; k < 2; k++) old_mem[k] = mem[254 + k];
    run_copy(254, 0, 4, 0, cyc, wrs);
    check("wrap_0", mem[0], old_mem[0]);
    check("wrap_1", mem[1], old_mem[1]);
    check("wrap_2", mem[2], old_mem[0]);
    check("wrap_3", mem[3], old_mem[1]);
    check_image("wrap_image");

    // Start while busy is ignored; next start after done is accepted
    run_copy(16, 128, 8, 3, cyc, wrs);
    check("busy_cycles", cyc, 21);
    check("busy_200", mem[200], exp_mem[200]);
    check_image("busy_image");
    run_copy(30, 90, 5, 0, cyc, wrs);
    check("restart_cycles", cyc, 15);
    check_image("restart_image");

    // Reset during the first odd-byte write of a len=6 copy
    for (int k = 0; k < 4; k++) poke(40 + k, 8'(8'hA0 + k));
    for (int k = 0; k < 6; k++) poke(100 + k, 8'h55);
    @(negedge clk);
    start = 1'b1;
    src = 8'd40;
    dst = 8'd100;
    len = 8'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_wr_en", mem_wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_wr_en_off", mem_wr_en, 0);
    check("rst_mid_busy", busy, 0);
    begin
      int dn;
      dn = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("rst_mid_no_done", dn, 0);
    end
    check("rst_mid_b0", mem[100], 8'hA0);
    check("rst_mid_b1", (mem[101] == 8'hA1 || mem[101] == 8'h55) ? 1 : 0, 1);
    for (int k = 2; k < 6; k++) check("rst_mid_untouched", mem[100 + k], 8'h55);
    exp_mem[100] = 8'hA0;
    exp_mem[101] = mem[101];

    // Reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    len = 8'd4;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 0);

    run_copy(40, 100, 6, 0, cyc, wrs);
    check("after_rst_cycles", cyc, 16);
    check_image("after_rst_image");

    // Randomized copies, overlap allowed
    for (int t = 0; t < 10; t++) begin
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 33));
      run_copy(s, d, l, 0, cyc, wrs);
      check("rand_cycles", cyc, 5 * (l / 2) + 4 * (l % 2) + 1);
      check("rand_writes", wrs, l);
      check_image("rand_image");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
